merge_n_arb: RTL and testbench



---
 rtl/merge_pkg.sv | 13 +
 rtl/merge_n_arb_rr.sv | 38 +++
 rtl/merge_n_arb.sv | 141 ++++++++++++++
 tb/tb_merge_n_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/merge_pkg.sv
// Shared definitions for the N-way merge and its round-robin arbiter.
// Holds the index-width helper and the merge mode encodings.
package merge_pkg;

   localparam int MODE_SEL = 0;
   localparam int MODE_RR  = 1;

   // Width of an index into n channels, never less than one bit.
   function automatic int idx_w(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/merge_n_arb_rr.sv
// Round-robin arbiter: the first requester after ptr wins.
// The search wraps modulo N, so ptr=N-1 starts the search at 0.
module rr_arbiter_n
   import merge_pkg::*;
#(
   parameter int N  = 5,
   parameter int SW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   input  logic          enable,
   output logic [N-1:0]  grant,
   output logic [SW-1:0] grant_idx,
   output logic          any
);

   logic w_found;
   int   w_j;

   // Scan ptr+1 .. ptr+N and keep the first requester found.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = |req;
      w_found   = 1'b0;
      w_j       = 0;
      for (int k = 1; k <= N; k++) begin
         w_j = int'(ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         if (!w_found && req[w_j]) begin
            w_found   = 1'b1;
            grant_idx = SW'(w_j);
            if (enable) grant[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/merge_n_arb.sv
// N-way merge forwarding one chosen input per transfer into a
// single output register; choice by select channel or round-robin.
module merge_n_arb
   import merge_pkg::*;
#(
   parameter  int N     = 5,
   parameter  int WIDTH = 32,
   parameter  int MODE  = 0,
   localparam int SW    = idx_w(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SW-1:0]      sel_data,
   input  logic               sel_valid,
   output logic               sel_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SW-1:0]      out_src,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               sel_err
);

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SW-1:0]    r_out_src;
   logic             r_sel_err;

   logic             w_can_load;
   logic             w_load;
   logic [SW-1:0]    w_load_idx;
   logic [WIDTH-1:0] w_load_data;
   logic             w_err_set;
   logic             w_sel_ok;
   logic             w_sel_iv;
   logic [N-1:0]     w_in_ready;
   logic             w_sel_ready;
   logic [N-1:0]     w_gnt_oh;
   logic [SW-1:0]    w_gnt_idx;
   logic             w_any;

   assign w_can_load = !r_out_valid || out_ready;

   generate
      if (MODE == MODE_RR) begin : g_rr
         logic [SW-1:0] r_ptr;

         rr_arbiter_n #(.N(N), .SW(SW)) u_arb (
            .req       (in_valid),
            .ptr       (r_ptr),
            .enable    (!rst && w_can_load),
            .grant     (w_gnt_oh),
            .grant_idx (w_gnt_idx),
            .any       (w_any)
         );

         // Priority pointer follows the last granted input.
         always_ff @(posedge clk) begin
            if (rst)         r_ptr <= SW'(N - 1);
            else if (w_load) r_ptr <= w_load_idx;
         end
      end else begin : g_sel
         assign w_gnt_oh  = '0;
         assign w_gnt_idx = '0;
         assign w_any     = 1'b0;
      end
   endgenerate

   // Decide which input (if any) is consumed and loaded this cycle.
   always_comb begin
      w_in_ready  = '0;
      w_sel_ready = 1'b0;
      w_load      = 1'b0;
      w_load_idx  = '0;
      w_err_set   = 1'b0;
      w_sel_ok    = 1'b0;
      w_sel_iv    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (sel_data == SW'(i)) begin
            w_sel_ok = 1'b1;
            w_sel_iv = in_valid[i];
         end
      end
      if (!rst) begin
         if (MODE == MODE_SEL) begin
            if (w_sel_ok) begin
               if (w_can_load && sel_valid && w_sel_iv) begin
                  w_in_ready[sel_data] = 1'b1;
                  w_sel_ready          = 1'b1;
                  w_load               = 1'b1;
                  w_load_idx           = sel_data;
               end
            end else begin
               w_sel_ready = w_can_load && sel_valid;
               w_err_set   = w_can_load && sel_valid;
            end
         end else if (w_can_load && w_any) begin
            w_in_ready = w_gnt_oh;
            w_load     = 1'b1;
            w_load_idx = w_gnt_idx;
         end
      end
   end

   // Data mux for the chosen input.
   always_comb begin
      w_load_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_load_idx == SW'(i)) w_load_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Output register plus one-cycle bad-select flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= '0;
         r_sel_err   <= 1'b0;
      end else begin
         r_sel_err <= w_err_set;
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_load_data;
            r_out_src   <= w_load_idx;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign sel_ready = w_sel_ready;
   assign out_data  = r_out_data;
   assign out_src   = r_out_src;
   assign out_valid = r_out_valid;
   assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_merge_n_arb.sv
// Directed bench for merge_n_arb: one select-mode and one
// round-robin instance sharing clock, reset and input data.
module tb_merge_n_arb;

   localparam int N  = 5;
   localparam int W  = 32;
   localparam int SW = 3;

   logic           clk = 1'b0;
   logic           rst;
   logic [N*W-1:0] in_data;

   logic [N-1:0]   a_valid, a_ready;
   logic [SW-1:0]  a_sel;
   logic           a_sel_valid, a_sel_ready;
   logic [W-1:0]   a_odata;
   logic [SW-1:0]  a_osrc;
   logic           a_ovalid, a_oready, a_err;

   logic [N-1:0]   b_valid, b_ready;
   logic [SW-1:0]  b_sel;
   logic           b_sel_valid, b_sel_ready;
   logic [W-1:0]   b_odata;
   logic [SW-1:0]  b_osrc;
   logic           b_ovalid, b_oready, b_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   merge_n_arb #(.N(N), .WIDTH(W), .MODE(0)) u_sel (
      .clk(clk), .rst(rst), .in_data(in_data),
      .in_valid(a_valid), .in_ready(a_ready),
      .sel_data(a_sel), .sel_valid(a_sel_valid), .sel_ready(a_sel_ready),
      .out_data(a_odata), .out_src(a_osrc), .out_valid(a_ovalid),
      .out_ready(a_oready), .sel_err(a_err)
   );

   merge_n_arb #(.N(N), .WIDTH(W), .MODE(1)) u_rr (
      .clk(clk), .rst(rst), .in_data(in_data),
      .in_valid(b_valid), .in_ready(b_ready),
      .sel_data(b_sel), .sel_valid(b_sel_valid), .sel_ready(b_sel_ready),
      .out_data(b_odata), .out_src(b_osrc), .out_valid(b_ovalid),
      .out_ready(b_oready), .sel_err(b_err)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'hA0 + i;
      rst = 1'b1;
      a_valid = 5'b11111; a_sel = 3'd0; a_sel_valid = 1'b1; a_oready = 1'b1;
      b_valid = 5'b11111; b_sel = 3'd0; b_sel_valid = 1'b1; b_oready = 1'b1;
      b_sel = 3'd0;
      tick();
      tick();
      chk("rst_a_rdy", a_ready, 0);
      chk("rst_a_srdy", a_sel_ready, 0);
      chk("rst_b_rdy", b_ready, 0);
      chk("rst_b_srdy", b_sel_ready, 0);
      chk("rst_a_ov", a_ovalid, 0);
      chk("rst_a_od", a_odata, 0);
      chk("rst_a_os", a_osrc, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_b_ov", b_ovalid, 0);

      // Select mode: pick input 3 out of five valid inputs.
      rst = 1'b0;
      b_valid = '0; b_sel_valid = 1'b0;
      a_valid = 5'b11111; a_sel = 3'd3; a_sel_valid = 1'b1;
      #1;
      chk("sel3_rdy", a_ready, 5'b01000);
      chk("sel3_srdy", a_sel_ready, 1);
      tick();
      a_sel_valid = 1'b0;
      chk("sel3_ov", a_ovalid, 1);
      chk("sel3_od", a_odata, 32'hA3);
      chk("sel3_os", a_osrc, 3);
      #1;
      chk("sel3_idle_rdy", a_ready, 0);
      tick();
      chk("sel3_drain", a_ovalid, 0);

      // Out-of-range select.
      a_sel = 3'd6; a_sel_valid = 1'b1;
      #1;
      chk("bad_srdy", a_sel_ready, 1);
      chk("bad_rdy", a_ready, 0);
      tick();
      a_sel_valid = 1'b0;
      chk("bad_err", a_err, 1);
      chk("bad_ov", a_ovalid, 0);
      tick();
      chk("bad_err_clr", a_err, 0);

      // Selected input not valid for three cycles.
      a_sel = 3'd2; a_sel_valid = 1'b1; a_valid = 5'b11011;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_rdy", a_ready, 0);
         chk("stall_srdy", a_sel_ready, 0);
         tick();
         chk("stall_ov", a_ovalid, 0);
      end
      a_valid = 5'b11111;
      #1;
      chk("stall_go_rdy", a_ready, 5'b00100);
      tick();
      a_sel_valid = 1'b0;
      chk("stall_od", a_odata, 32'hA2);
      chk("stall_os", a_osrc, 2);

      // Round-robin, all inputs valid.
      b_valid = 5'b11111;
      #1;
      chk("rr_first_rdy", b_ready, 5'b00001);
      chk("rr_srdy", b_sel_ready, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("rr_all_os", b_osrc, k % N);
         chk("rr_all_od", b_odata, 32'hA0 + (k % N));
         chk("rr_all_ov", b_ovalid, 1);
      end

      // Only inputs 1 and 4 valid.
      b_valid = 5'b10010;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rr_14_os", b_osrc, (k % 2 == 0) ? 1 : 4);
      end

      // Backpressure while holding src 4.
      b_valid = 5'b11111; b_oready = 1'b0;
      #1;
      chk("bp_rdy0", b_ready, 0);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("bp_os", b_osrc, 4);
         chk("bp_od", b_odata, 32'hA4);
         chk("bp_ov", b_ovalid, 1);
         chk("bp_rdy", b_ready, 0);
      end
      b_oready = 1'b1;
      #1;
      chk("bp_rel_rdy", b_ready, 5'b00001);
      tick();
      chk("bp_rel_os", b_osrc, 0);
      chk("bp_rel_od", b_odata, 32'hA0);

      // Reset with output full and every input valid.
      rst = 1'b1;
      a_valid = 5'b11111; a_sel = 3'd1; a_sel_valid = 1'b1;
      #1;
      chk("mrst_b_rdy", b_ready, 0);
      chk("mrst_a_rdy", a_ready, 0);
      chk("mrst_a_srdy", a_sel_ready, 0);
      tick();
      chk("mrst_b_ov", b_ovalid, 0);
      chk("mrst_b_os", b_osrc, 0);
      a_sel_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("post_rst_rdy", b_ready, 5'b00001);
      tick();
      chk("post_rst_os", b_osrc, 0);
      chk("post_rst_ov", b_ovalid, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
